// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the ibus/dbus memory arbiter:
// FSM state encoding, bus width constants and a fetch word-align helper.
package mem_bus_arbiter_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    // Fetches are always whole words; drop the byte offset.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Loadable/clearable saturating counter with an expiry flag.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   clr             - clear count to zero (wins over load/inc)
//   load, load_val  - load an explicit count value
//   inc             - increment by one, saturating at all-ones
//   limit           - expiry threshold
//   expired         - count has reached limit
module arb_timeout_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count;

    // Count register
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign expired = (count >= limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the instruction-fetch port
// (ibus) and the load/store port (dbus). Data has priority; fetch is forced
// after STARVE_LIMIT consecutive data grants taken while a fetch waits.
// Hung transactions are aborted after TIMEOUT busy cycles with bus_err.
// Ports:
//   clk, reset                - clock, synchronous active-high reset
//   ibus_req/addr             - fetch request (held until ibus_ready)
//   ibus_ready/rdata          - fetch completion pulse and data
//   dbus_req/we/addr/wdata/wstrb - data request (held until dbus_ready)
//   dbus_ready/rdata          - data completion pulse and load data
//   bus_err                   - pulses with the ready of a timed-out access
//   mem_req/we/addr/wdata/wstrb - registered memory request
//   mem_ready/rdata           - memory completion pulse and read data
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ibus_req,
    input  logic [ADDR_W-1:0] ibus_addr,
    output logic              ibus_ready,
    output logic [DATA_W-1:0] ibus_rdata,
    input  logic              dbus_req,
    input  logic              dbus_we,
    input  logic [ADDR_W-1:0] dbus_addr,
    input  logic [DATA_W-1:0] dbus_wdata,
    input  logic [STRB_W-1:0] dbus_wstrb,
    output logic              dbus_ready,
    output logic [DATA_W-1:0] dbus_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       SCNT_W     = 4;
    localparam int unsigned       TCNT_W     = 8;
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);
    // Counter holds the number of elapsed busy cycles, so expiry on the
    // TIMEOUT-th busy cycle means a threshold of TIMEOUT-1.
    localparam logic [TCNT_W-1:0] TO_LIMIT   = TCNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [SCNT_W-1:0]  starve_cnt;
    logic               grant_i;
    logic               grant_d;
    logic               busy;
    logic               expired;
    logic               done;
    logic               own_i;
    logic               own_d;

    assign busy  = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
    assign own_i = (state == ARB_BUSY_I) && !reset;
    assign own_d = (state == ARB_BUSY_D) && !reset;
    assign done  = busy && (mem_ready || expired);

    // Busy-cycle watchdog; idle clears it so every grant starts from zero
    arb_timeout_counter #(
        .WIDTH (TCNT_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (!busy),
        .load     (1'b0),
        .load_val ('0),
        .inc      (busy && !mem_ready),
        .limit    (TO_LIMIT),
        .expired  (expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant decision
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dbus_req && (starve_cnt < STARVE_MAX)) begin
                    grant_d = 1'b1;
                end else if (ibus_req) begin
                    grant_i = 1'b1;
                end else if (dbus_req) begin
                    grant_d = 1'b1;
                end
                if (grant_d) begin
                    state_next = ARB_BUSY_D;
                end else if (grant_i) begin
                    state_next = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (done) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Memory request fields latched at grant, held for the whole transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= word_align(ibus_addr);
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= dbus_we;
            mem_addr  <= dbus_addr;
            mem_wdata <= dbus_wdata;
            mem_wstrb <= dbus_wstrb;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Consecutive data grants taken while a fetch was waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            if (!ibus_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + SCNT_W'(1);
            end
        end
    end

    // Completion signalling; a real mem_ready beats a coincident expiry
    assign ibus_ready = own_i && done;
    assign dbus_ready = own_d && done;
    assign bus_err    = (own_i || own_d) && expired && !mem_ready;
    assign ibus_rdata = (own_i && mem_ready) ? mem_rdata : '0;
    assign dbus_rdata = (own_d && mem_ready) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: two instances share stimulus,
// one with TIMEOUT=8 (main checks) and one with TIMEOUT=4 (coincidence case).
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ibus_req = 1'b0;
    logic [31:0] ibus_addr = '0;
    logic        dbus_req = 1'b0;
    logic        dbus_we = 1'b0;
    logic [31:0] dbus_addr = '0;
    logic [31:0] dbus_wdata = '0;
    logic [3:0]  dbus_wstrb = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        ibus_ready, dbus_ready, bus_err, mem_req, mem_we;
    logic [31:0] ibus_rdata, dbus_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    logic        q4_ibus_ready, q4_dbus_ready, q4_bus_err, q4_mem_req, q4_mem_we;
    logic [31:0] q4_ibus_rdata, q4_dbus_rdata, q4_mem_addr, q4_mem_wdata;
    logic [3:0]  q4_mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int stray;

    logic [1:0] exp_seq [10] = '{ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_I,
                                 ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_D, ARB_BUSY_I};

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ready(ibus_ready), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata),
        .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ready(q4_ibus_ready), .ibus_rdata(q4_ibus_rdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb),
        .dbus_ready(q4_dbus_ready), .dbus_rdata(q4_dbus_rdata),
        .bus_err(q4_bus_err),
        .mem_req(q4_mem_req), .mem_we(q4_mem_we), .mem_addr(q4_mem_addr),
        .mem_wdata(q4_mem_wdata), .mem_wstrb(q4_mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Inputs change 2 time units after the edge, outputs are sampled 1 later
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Record one check result
    task automatic chk(input bit ok, input string tag);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        tick(); tick(); settle();
        chk(dut.state === ARB_IDLE, "rst_state");
        chk(mem_req === 1'b0, "rst_mem_req");
        chk(mem_we === 1'b0, "rst_mem_we");
        chk(mem_addr === 32'h0, "rst_mem_addr");
        chk(mem_wdata === 32'h0, "rst_mem_wdata");
        chk(mem_wstrb === 4'h0, "rst_mem_wstrb");
        chk({ibus_ready, dbus_ready, bus_err} === 3'b000, "rst_readies");
        reset = 1'b0;

        // Single fetch, mem_ready 3 cycles after mem_req
        tick();
        ibus_req = 1'b1; ibus_addr = 32'h0000_1006; mem_rdata = 32'h1111_2222;
        settle();
        chk(ibus_ready === 1'b0, "t1_idle_ready");
        tick(); settle();
        chk(mem_req === 1'b1, "t1_mem_req");
        chk(mem_addr === 32'h0000_1004, "t1_mem_addr");
        chk(mem_we === 1'b0, "t1_mem_we");
        chk(mem_wstrb === 4'h0, "t1_mem_wstrb");
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) begin
                tick(); settle();
            end
            pulses += int'(ibus_ready);
        end
        chk(ibus_rdata === 32'h0, "t1_wait_rdata");
        tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        chk(ibus_ready === 1'b1, "t1_ready");
        chk(ibus_rdata === 32'hDEAD_BEEF, "t1_rdata");
        chk(dbus_ready === 1'b0, "t1_no_dbus_ready");
        chk(bus_err === 1'b0, "t1_no_err");
        pulses += int'(ibus_ready);
        tick();
        mem_ready = 1'b0; ibus_req = 1'b0;
        settle();
        chk(mem_req === 1'b0, "t1_mem_req_drop");
        pulses += int'(ibus_ready);
        tick(); settle();
        pulses += int'(ibus_ready);
        chk(pulses === 1, "t1_pulse_count");

        // Simultaneous ibus and dbus store: data first, fetch after one idle cycle
        tick();
        ibus_req = 1'b1; ibus_addr = 32'h0000_2000;
        dbus_req = 1'b1; dbus_we = 1'b1; dbus_addr = 32'h0000_0080;
        dbus_wdata = 32'h1234_5678; dbus_wstrb = 4'b0011;
        settle();
        tick(); settle();
        chk(dut.state === ARB_BUSY_D, "t2_state_d");
        chk(mem_we === 1'b1, "t2_mem_we");
        chk(mem_addr === 32'h0000_0080, "t2_mem_addr");
        chk(mem_wdata === 32'h1234_5678, "t2_mem_wdata");
        chk(mem_wstrb === 4'b0011, "t2_mem_wstrb");
        mem_ready = 1'b1; mem_rdata = 32'h0;
        settle();
        chk(dbus_ready === 1'b1, "t2_dbus_ready");
        chk(ibus_ready === 1'b0, "t2_ibus_not_ready");
        tick();
        mem_ready = 1'b0; dbus_req = 1'b0; dbus_we = 1'b0;
        settle();
        chk(dut.state === ARB_IDLE, "t2_idle_gap");
        chk(mem_req === 1'b0, "t2_idle_mem_req");
        tick(); settle();
        chk(dut.state === ARB_BUSY_I, "t2_state_i");
        chk(mem_addr === 32'h0000_2000, "t2_fetch_addr");
        chk(mem_we === 1'b0, "t2_fetch_we");
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        settle();
        chk(ibus_rdata === 32'hA5A5_0001, "t2_fetch_rdata");
        tick();
        mem_ready = 1'b0; ibus_req = 1'b0;
        settle();

        // Starvation bound: both held, expect D,D,D,D,I,D,D,D,D,I
        tick();
        ibus_req = 1'b1; ibus_addr = 32'h0000_3000;
        dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h0000_0100;
        settle();
        for (int i = 0; i < 10; i++) begin
            tick(); settle();
            chk(dut.state === exp_seq[i], $sformatf("t3_grant%0d", i));
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            if (i == 9) begin
                ibus_req = 1'b0;
                dbus_req = 1'b0;
            end
            settle();
        end

        // Timeout with TIMEOUT=8, then a stray late mem_ready
        tick();
        dbus_req = 1'b1; dbus_we = 1'b0; dbus_addr = 32'h0000_0040;
        mem_rdata = 32'h0BAD_0BAD;
        settle();
        stray = 0;
        for (int b = 1; b <= 7; b++) begin
            tick(); settle();
            stray += int'(dbus_ready) + int'(bus_err);
        end
        chk(stray === 0, "t4_no_early_ready");
        tick(); settle();
        chk(dbus_ready === 1'b1, "t4_dbus_ready");
        chk(bus_err === 1'b1, "t4_bus_err");
        chk(dbus_rdata === 32'h0, "t4_rdata_zero");
        chk(ibus_ready === 1'b0, "t4_ibus_quiet");
        dbus_req = 1'b0;
        tick(); settle();
        chk(mem_req === 1'b0, "t4_mem_req_drop");
        chk(dut.state === ARB_IDLE, "t4_state_idle");
        tick();
        mem_ready = 1'b1;
        settle();
        chk({ibus_ready, dbus_ready, bus_err} === 3'b000, "t4_stray_ready");
        tick();
        mem_ready = 1'b0;
        settle();
        chk(dut.state === ARB_IDLE, "t4_stray_state");
        chk(mem_req === 1'b0, "t4_stray_mem_req");

        // Reset two cycles into a fetch, then a fresh fetch
        tick();
        ibus_req = 1'b1; ibus_addr = 32'h0000_3008;
        settle();
        tick(); settle();
        chk(dut.state === ARB_BUSY_I, "t5_busy");
        tick();
        reset = 1'b1;
        settle();
        chk(ibus_ready === 1'b0, "t5_rst_no_ready");
        tick();
        reset = 1'b0; ibus_addr = 32'h0000_3010;
        settle();
        chk(dut.state === ARB_IDLE, "t5_state_idle");
        chk(mem_req === 1'b0, "t5_mem_req");
        chk(ibus_ready === 1'b0, "t5_no_ready");
        tick(); settle();
        chk(dut.state === ARB_BUSY_I, "t5_regrant");
        chk(mem_addr === 32'h0000_3010, "t5_addr");
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        settle();
        chk(ibus_ready === 1'b1, "t5_ready");
        chk(ibus_rdata === 32'hCAFE_F00D, "t5_rdata");
        tick();
        mem_ready = 1'b0; ibus_req = 1'b0;
        settle();

        // mem_ready on the 4th busy cycle of the TIMEOUT=4 instance
        tick();
        ibus_req = 1'b1; ibus_addr = 32'h0000_0500;
        settle();
        tick(); settle();
        chk(dut4.state === ARB_BUSY_I, "t6_busy");
        tick(); tick();
        settle();
        chk({q4_ibus_ready, q4_bus_err} === 2'b00, "t6_no_early_err");
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h600D_D47A;
        settle();
        chk(q4_ibus_ready === 1'b1, "t6_ready");
        chk(q4_bus_err === 1'b0, "t6_no_err");
        chk(q4_ibus_rdata === 32'h600D_D47A, "t6_rdata");
        tick();
        mem_ready = 1'b0; ibus_req = 1'b0;
        settle();
        chk(q4_mem_req === 1'b0, "t6_mem_req_drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction-fetch port (ibus) and its load/store port (dbus). Sits between the pipelined RV32I core and the unified memory/SRAM controller.
- Each requester sees a req/ready handshake.
- The arbiter holds the memory port for one transaction at a time.
- Data gets priority, with a bounded-starvation guarantee for fetch.
- Includes a response timeout that terminates hung transactions with an error.

Parameters:
STARVE_LIMIT, 4, max consecutive dbus grants while ibus_req is pending before ibus is forced next (1..15)
TIMEOUT, 255, cycles to wait for mem_ready before aborting the transaction (1..255; 8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ibus_req  in  1  fetch request; held with ibus_addr stable until ibus_ready
ibus_addr  in  32  fetch byte address
ibus_ready  out  1  one-cycle pulse: fetch complete, ibus_rdata valid
ibus_rdata  out  32  fetch data
dbus_req  in  1  data request; held with all dbus_* inputs stable until dbus_ready
dbus_we  in  1  1=store, 0=load
dbus_addr  in  32  data byte address
dbus_wdata  in  32  store data
dbus_wstrb  in  4  store byte enables
dbus_ready  out  1  one-cycle pulse: data access complete
dbus_rdata  out  32  load data
bus_err  out  1  one-cycle pulse with the ready of a timed-out transaction
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable
mem_addr  out  32  memory address
mem_wdata  out  32  memory write data
mem_wstrb  out  4  memory byte enables
mem_ready  in  1  one-cycle pulse: memory completed current request
mem_rdata  in  32  memory read data, valid when mem_ready

Behaviour:
- Reset values:
  - State IDLE.
  - mem_req, mem_we, ibus_ready, dbus_ready and bus_err are 0.
  - mem_addr, mem_wdata and mem_wstrb are 0.
  - Starvation and timeout counters are 0.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - If dbus_req and the starvation counter is below STARVE_LIMIT: go to BUSY_D.
  - Else if ibus_req: go to BUSY_I.
  - Else if dbus_req (counter at limit, no fetch pending): go to BUSY_D.
  - On the transition edge, register the mem_* fields from the chosen requester and set mem_req=1.
- Fetch fields:
  - mem_we=0, mem_wstrb=0.
  - mem_addr = {ibus_addr[31:2], 2'b00}.
- Data fields:
  - dbus fields pass through unmodified; no alignment check.
- Latency: req seen in IDLE at cycle N; mem_req high from cycle N+1; minimum request-to-ready is 2 cycles.
- BUSY_x:
  - mem_req and the mem_* fields stay constant.
  - On mem_ready in the same cycle:
    - Assert the owner's *_ready combinationally, with *_rdata = mem_rdata.
    - Register mem_req to 0 and return to IDLE.
  - IDLE always lasts at least one cycle between transactions; no back-to-back grant.
- Starvation counter:
  - Increments on each dbus grant made while ibus_req=1, saturating at STARVE_LIMIT.
  - Clears on any ibus grant, and on a dbus grant made with ibus_req=0.
- Timeout:
  - The counter clears on grant and increments each BUSY cycle without mem_ready.
  - On reaching TIMEOUT:
    - Pulse the owner's *_ready and bus_err for 1 cycle, with *_rdata=0.
    - Drop mem_req and go to IDLE.
  - A late mem_ready arriving in IDLE is ignored.
- Simultaneous mem_ready and timeout expiry in the same cycle: mem_ready wins, bus_err=0, real data returned.
- Protocol violation (requester drops req mid-transaction): the transaction completes anyway and the ready pulse is still issued.
- Reset mid-transaction: forces IDLE and mem_req=0 on the next edge; the pending transaction is abandoned with no ready pulse.
- *_ready pulses never occur for the non-owner; *_rdata is 0 when the corresponding ready is 0.

Decomposition:
- Shared package holds:
  - FSM state encoding (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D).
  - Bus width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
- One natural sub-module: arb_timeout_counter.
  - Loadable/clearable saturating 8-bit counter with an expiry flag.
  - The same module is reused later for the dbus-side peripheral watchdog.

Test Plan:
- Single fetch, mem_ready 3 cycles after mem_req, ibus_addr=0x0000_1006:
  - Required: mem_addr=0x0000_1004, mem_we=0, mem_wstrb=0.
  - Required: ibus_ready pulses exactly once with mem_rdata=0xDEAD_BEEF forwarded.
- ibus_req and dbus_req (store 0x1234_5678 to 0x80, wstrb=4'b0011) raised in the same cycle:
  - Required: dbus granted first with mem_we=1 and mem_wdata/mem_wstrb passed through.
  - Required: ibus granted after one IDLE cycle.
- dbus_req held continuously with ibus_req held, STARVE_LIMIT=4:
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I.
- mem_ready never asserted, TIMEOUT=8:
  - Required: on the 8th BUSY cycle, dbus_ready=1, bus_err=1, dbus_rdata=0, then mem_req=0.
  - Required: a stray mem_ready 2 cycles later produces no ready pulse.
- reset asserted 2 cycles into a BUSY_I transaction:
  - Required: next cycle state IDLE, mem_req=0, no ibus_ready.
  - Required: a fresh fetch after reset completes normally.
- mem_ready and timeout expiry coincide (TIMEOUT=4, mem_ready on 4th BUSY cycle):
  - Required: ready=1, bus_err=0, rdata=mem_rdata.
